run_controller: RTL and testbench

RUN_CONTROLLER -- requirements
Module: run_controller

---
 rtl/run_ctrl_pkg.sv | 32 +++
 rtl/popcount_n.sv | 17 +
 rtl/run_controller.sv | 180 ++++++++++++++++++
 tb/tb_run_controller.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and default constants for the CPU run controller.
// The FSM encoding lives here so benches and debug tooling decode dbg_state identically.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HOLD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_TOUT = 3'd4
    } run_state_e;

    localparam int DEF_N_CH       = 1;
    localparam int DEF_CNT_W      = 32;
    localparam int DEF_RST_CYCLES = 2;
    localparam int DEF_MAX_CYCLES = 2500;
    localparam int DEF_HALT_ALL   = 1;

    localparam int HOLD_W = 8;

    // Keeps the hold counter load inside its legal 1..255 window.
    function automatic logic [HOLD_W-1:0] hold_load(input int cycles);
        if (cycles < 1) begin
            return HOLD_W'(1);
        end
        if (cycles > ((1 << HOLD_W) - 1)) begin
            return HOLD_W'((1 << HOLD_W) - 1);
        end
        return HOLD_W'(cycles);
    endfunction

endpackage

// File: rtl/popcount_n.sv
// Combinational population count of an N-bit vector.
module popcount_n #(
    parameter int N = 1,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0] bits,
    output logic [W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + W'(bits[i]);
        end
    end

endmodule

// File: rtl/run_controller.sv
// Sequences a CPU through reset hold, a budgeted run and a sticky end state,
// counting run cycles and retired instructions across all harts.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int HALT_ALL   = DEF_HALT_ALL
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [N_CH-1:0]  halt_req,
    input  logic [N_CH-1:0]  retire,
    output logic             cpu_reset,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [N_CH-1:0]  halt_mask,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count,
    output run_state_e       dbg_state
);

    localparam int PC_W  = $clog2(N_CH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  BUDGET    = CNT_W'(MAX_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = hold_load(RST_CYCLES);

    run_state_e        state;
    run_state_e        next_state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_d;

    logic              cpu_reset_d;
    logic              running_d;
    logic              done_d;
    logic              timeout_d;
    logic [N_CH-1:0]   halt_mask_d;
    logic [CNT_W-1:0]  cycle_d;
    logic [CNT_W-1:0]  retire_d;

    logic [N_CH-1:0]   halt_now;
    logic              end_met;
    logic              budget_hit;
    logic [CNT_W-1:0]  cycle_inc;
    logic [CNT_W-1:0]  retire_inc;
    logic [PC_W-1:0]   retire_pop;
    logic [SUM_W-1:0]  retire_sum;

    popcount_n #(
        .N (N_CH),
        .W (PC_W)
    ) u_retire_pop (
        .bits  (retire),
        .count (retire_pop)
    );

    // The current cycle's halt requests count toward the end condition immediately.
    assign halt_now   = halt_mask | halt_req;
    assign end_met    = (HALT_ALL != 0) ? (&halt_now) : (|halt_now);

    assign cycle_inc  = (cycle_count == CNT_MAX) ? CNT_MAX : (cycle_count + 1'b1);
    assign retire_sum = SUM_W'(retire_count) + SUM_W'(retire_pop);
    assign retire_inc = (retire_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : retire_sum[CNT_W-1:0];
    assign budget_hit = (cycle_inc >= BUDGET);

    assign dbg_state  = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            hold_cnt     <= '0;
            cpu_reset    <= 1'b1;
            running      <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            halt_mask    <= '0;
            cycle_count  <= '0;
            retire_count <= '0;
        end else begin
            state        <= next_state;
            hold_cnt     <= hold_d;
            cpu_reset    <= cpu_reset_d;
            running      <= running_d;
            done         <= done_d;
            timeout      <= timeout_d;
            halt_mask    <= halt_mask_d;
            cycle_count  <= cycle_d;
            retire_count <= retire_d;
        end
    end

    // Halt completion wins over budget exhaustion when both land on the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt <= HOLD_W'(1)) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (end_met) begin
                    next_state = ST_DONE;
                end else if (budget_hit) begin
                    next_state = ST_TOUT;
                end
            end
            ST_DONE, ST_TOUT: begin
                if (start) begin
                    next_state = ST_HOLD;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Next values for the registered outputs; anything not touched holds.
    always_comb begin
        hold_d      = hold_cnt;
        cpu_reset_d = (next_state != ST_RUN);
        running_d   = (next_state == ST_RUN);
        done_d      = done;
        timeout_d   = timeout;
        halt_mask_d = halt_mask;
        cycle_d     = cycle_count;
        retire_d    = retire_count;

        case (state)
            ST_IDLE, ST_DONE, ST_TOUT: begin
                if (start) begin
                    hold_d      = HOLD_LOAD;
                    done_d      = 1'b0;
                    timeout_d   = 1'b0;
                    halt_mask_d = '0;
                    cycle_d     = '0;
                    retire_d    = '0;
                end
            end
            ST_HOLD: begin
                if (hold_cnt != '0) begin
                    hold_d = hold_cnt - 1'b1;
                end
            end
            ST_RUN: begin
                cycle_d     = cycle_inc;
                retire_d    = retire_inc;
                halt_mask_d = halt_now;
                if (end_met) begin
                    done_d = 1'b1;
                end else if (budget_hit) begin
                    timeout_d = 1'b1;
                end
            end
            default: begin
                hold_d = '0;
            end
        endcase
    end

    a_flags_exclusive : assert property (@(posedge clk) disable iff (!reset_n)
        !(done && timeout));
    a_running_in_run  : assert property (@(posedge clk) disable iff (!reset_n)
        running == (state == ST_RUN));
    a_reset_vs_run    : assert property (@(posedge clk) disable iff (!reset_n)
        cpu_reset == !running);

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: three differently parameterised instances driven together
// and checked every cycle against a behavioural model, plus directed scenario checks.
module tb_run_controller;
    import run_ctrl_pkg::*;

    localparam int NI = 3;
    localparam int NCH0 = 1,    NCH1 = 2,  NCH2 = 2;
    localparam int CW0  = 32,   CW1  = 16, CW2  = 4;
    localparam int RST0 = 2,    RST1 = 2,  RST2 = 3;
    localparam int MAX0 = 2500, MAX1 = 50, MAX2 = 12;
    localparam int ALL0 = 1,    ALL1 = 1,  ALL2 = 0;

    localparam int M_IDLE = 0, M_HOLD = 1, M_RUN = 2, M_DONE = 3, M_TOUT = 4;

    int p_nch [NI];
    int p_cw  [NI];
    int p_rst [NI];
    int p_max [NI];
    int p_all [NI];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_v [NI];
    logic [7:0] halt_v  [NI];
    logic [7:0] ret_v   [NI];

    logic        cpu_reset_w [NI];
    logic        running_w   [NI];
    logic        done_w      [NI];
    logic        tout_w      [NI];
    logic [7:0]  mask_w      [NI];
    logic [31:0] cyc_w       [NI];
    logic [31:0] rc_w        [NI];
    run_state_e  st_w        [NI];

    logic [0:0]  mask0;
    logic [1:0]  mask1, mask2;
    logic [31:0] cyc0, rc0;
    logic [15:0] cyc1, rc1;
    logic [3:0]  cyc2, rc2;

    assign mask_w[0] = {7'b0, mask0};
    assign mask_w[1] = {6'b0, mask1};
    assign mask_w[2] = {6'b0, mask2};
    assign cyc_w[0]  = cyc0;
    assign cyc_w[1]  = {16'b0, cyc1};
    assign cyc_w[2]  = {28'b0, cyc2};
    assign rc_w[0]   = rc0;
    assign rc_w[1]   = {16'b0, rc1};
    assign rc_w[2]   = {28'b0, rc2};

    run_controller #(.N_CH(NCH0), .CNT_W(CW0), .RST_CYCLES(RST0), .MAX_CYCLES(MAX0), .HALT_ALL(ALL0)) u0 (
        .clk(clk), .reset_n(rst_n), .start(start_v[0]), .halt_req(halt_v[0][0:0]), .retire(ret_v[0][0:0]),
        .cpu_reset(cpu_reset_w[0]), .running(running_w[0]), .done(done_w[0]), .timeout(tout_w[0]),
        .halt_mask(mask0), .cycle_count(cyc0), .retire_count(rc0), .dbg_state(st_w[0]));

    run_controller #(.N_CH(NCH1), .CNT_W(CW1), .RST_CYCLES(RST1), .MAX_CYCLES(MAX1), .HALT_ALL(ALL1)) u1 (
        .clk(clk), .reset_n(rst_n), .start(start_v[1]), .halt_req(halt_v[1][1:0]), .retire(ret_v[1][1:0]),
        .cpu_reset(cpu_reset_w[1]), .running(running_w[1]), .done(done_w[1]), .timeout(tout_w[1]),
        .halt_mask(mask1), .cycle_count(cyc1), .retire_count(rc1), .dbg_state(st_w[1]));

    run_controller #(.N_CH(NCH2), .CNT_W(CW2), .RST_CYCLES(RST2), .MAX_CYCLES(MAX2), .HALT_ALL(ALL2)) u2 (
        .clk(clk), .reset_n(rst_n), .start(start_v[2]), .halt_req(halt_v[2][1:0]), .retire(ret_v[2][1:0]),
        .cpu_reset(cpu_reset_w[2]), .running(running_w[2]), .done(done_w[2]), .timeout(tout_w[2]),
        .halt_mask(mask2), .cycle_count(cyc2), .retire_count(rc2), .dbg_state(st_w[2]));

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: one entry per instance, phases named after the spec's states.
    int         m_ph   [NI];
    int         m_hold [NI];
    longint     m_cyc  [NI];
    longint     m_ret  [NI];
    logic [7:0] m_mask [NI];
    bit         m_done [NI];
    bit         m_tout [NI];

    task automatic model_clear(input int j);
        m_cyc[j]  = 0;
        m_ret[j]  = 0;
        m_mask[j] = 8'h00;
        m_done[j] = 1'b0;
        m_tout[j] = 1'b0;
    endtask

    task automatic model_step(input int j);
        longint     top = (longint'(1) << p_cw[j]) - 1;
        logic [7:0] chm = 8'((1 << p_nch[j]) - 1);
        bit         fin;
        if (!rst_n) begin
            m_ph[j]   = M_IDLE;
            m_hold[j] = 0;
            model_clear(j);
        end else begin
            case (m_ph[j])
                M_IDLE, M_DONE, M_TOUT: begin
                    if (start_v[j]) begin
                        model_clear(j);
                        m_ph[j]   = M_HOLD;
                        m_hold[j] = p_rst[j];
                    end
                end
                M_HOLD: begin
                    m_hold[j] = m_hold[j] - 1;
                    if (m_hold[j] == 0) m_ph[j] = M_RUN;
                end
                M_RUN: begin
                    m_cyc[j]  = (m_cyc[j] + 1 > top) ? top : m_cyc[j] + 1;
                    m_ret[j]  = m_ret[j] + $countones(ret_v[j] & chm);
                    if (m_ret[j] > top) m_ret[j] = top;
                    m_mask[j] = m_mask[j] | (halt_v[j] & chm);
                    fin = (p_all[j] != 0) ? (m_mask[j] == chm) : (m_mask[j] != 8'h00);
                    if (fin) begin
                        m_ph[j]   = M_DONE;
                        m_done[j] = 1'b1;
                    end else if (m_cyc[j] >= p_max[j]) begin
                        m_ph[j]   = M_TOUT;
                        m_tout[j] = 1'b1;
                    end
                end
                default: m_ph[j] = M_IDLE;
            endcase
        end
    endtask

    function automatic run_state_e exp_state(input int ph);
        case (ph)
            M_HOLD:  return ST_HOLD;
            M_RUN:   return ST_RUN;
            M_DONE:  return ST_DONE;
            M_TOUT:  return ST_TOUT;
            default: return ST_IDLE;
        endcase
    endfunction

    task automatic compare_all();
        for (int j = 0; j < NI; j++) begin
            check($sformatf("u%0d.cpu_reset", j), 64'(cpu_reset_w[j]), 64'(m_ph[j] != M_RUN));
            check($sformatf("u%0d.running", j),   64'(running_w[j]),   64'(m_ph[j] == M_RUN));
            check($sformatf("u%0d.done", j),      64'(done_w[j]),      64'(m_done[j]));
            check($sformatf("u%0d.timeout", j),   64'(tout_w[j]),      64'(m_tout[j]));
            check($sformatf("u%0d.halt_mask", j), 64'(mask_w[j]),      64'(m_mask[j]));
            check($sformatf("u%0d.cycle_count", j),  64'(cyc_w[j]),    64'(m_cyc[j]));
            check($sformatf("u%0d.retire_count", j), 64'(rc_w[j]),     64'(m_ret[j]));
            check($sformatf("u%0d.state", j),     64'(st_w[j]),        64'(exp_state(m_ph[j])));
        end
    endtask

    // Inputs are driven at the falling edge; the model and DUT both sample at the rising edge.
    task automatic tick();
        @(posedge clk);
        for (int j = 0; j < NI; j++) model_step(j);
        @(negedge clk);
        compare_all();
    endtask

    task automatic clear_inputs();
        for (int j = 0; j < NI; j++) begin
            start_v[j] = 1'b0;
            halt_v[j]  = 8'h00;
            ret_v[j]   = 8'h00;
        end
    endtask

    initial begin
        int k1;
        int k2;
        p_nch = '{NCH0, NCH1, NCH2};
        p_cw  = '{CW0, CW1, CW2};
        p_rst = '{RST0, RST1, RST2};
        p_max = '{MAX0, MAX1, MAX2};
        p_all = '{ALL0, ALL1, ALL2};
        for (int j = 0; j < NI; j++) begin
            m_ph[j]   = M_IDLE;
            m_hold[j] = 0;
            model_clear(j);
        end

        rst_n = 1'b1;
        clear_inputs();
        #2 rst_n = 1'b0;
        repeat (3) tick();
        check("rst.cpu_reset", 64'(cpu_reset_w[0]), 64'd1);
        check("rst.running",   64'(running_w[0]),   64'd0);
        check("rst.done",      64'(done_w[1]),      64'd0);
        check("rst.timeout",   64'(tout_w[1]),      64'd0);
        check("rst.cycles",    64'(cyc_w[0]),       64'd0);
        check("rst.state",     64'(st_w[2]),        64'(ST_IDLE));

        rst_n = 1'b1;
        repeat (5) tick();

        // Start all three: hold timing, two-hart halt, retire saturation, any-halt timeout.
        for (int i = 0; i < 30; i++) begin
            clear_inputs();
            for (int j = 0; j < NI; j++) start_v[j] = (i == 0);
            k1 = i - (RST1 + 1);
            k2 = i - (RST2 + 1);
            if (k1 == 10) halt_v[1] = 8'h01;
            if (k1 == 20) halt_v[1] = 8'h02;
            if (k2 >= 0 && k2 < 10) ret_v[2] = 8'h03;
            tick();
            if (i == 0) begin
                check("hold.cpu_reset_e0", 64'(cpu_reset_w[0]), 64'd1);
                check("hold.running_e0",   64'(running_w[0]),   64'd0);
            end
            if (i == 1) check("hold.cpu_reset_e1", 64'(cpu_reset_w[0]), 64'd1);
            if (i == 2) begin
                check("hold.cpu_reset_e2", 64'(cpu_reset_w[0]), 64'd0);
                check("hold.running_e2",   64'(running_w[0]),   64'd1);
            end
            if (i == RST1 + 1 + 20) begin
                check("halt2.done",    64'(done_w[1]), 64'd1);
                check("halt2.timeout", 64'(tout_w[1]), 64'd0);
                check("halt2.mask",    64'(mask_w[1]), 64'd3);
                check("halt2.cycles",  64'(cyc_w[1]),  64'd21);
            end
            if (i == RST2 + 1 + 9) check("sat.retire", 64'(rc_w[2]), 64'd15);
            if (i == 29) begin
                check("sat.timeout", 64'(tout_w[2]), 64'd1);
                check("sat.cycles",  64'(cyc_w[2]),  64'd12);
            end
        end

        // u1 budget timeout with an ignored mid-run start; u2 ends on a single halting hart.
        for (int i = 0; i < 60; i++) begin
            clear_inputs();
            start_v[1] = (i == 0 || i == 20);
            start_v[2] = (i == 0);
            ret_v[1]   = 8'($urandom);
            k2 = i - (RST2 + 1);
            if (k2 == 3) halt_v[2] = 8'h02;
            tick();
            if (i == 21) check("tout.start_ignored", 64'(running_w[1]), 64'd1);
            if (i == 59) begin
                check("tout.timeout",   64'(tout_w[1]),      64'd1);
                check("tout.done",      64'(done_w[1]),      64'd0);
                check("tout.cycles",    64'(cyc_w[1]),       64'd50);
                check("tout.cpu_reset", 64'(cpu_reset_w[1]), 64'd1);
                check("any.done",       64'(done_w[2]),      64'd1);
                check("any.mask",       64'(mask_w[2]),      64'd2);
                check("any.cycles",     64'(cyc_w[2]),       64'd4);
            end
        end

        // u1 halts on the very cycle that exhausts the budget; hold-phase inputs are ignored.
        for (int i = 0; i < 60; i++) begin
            clear_inputs();
            start_v[1] = (i == 0);
            if (i == 1 || i == 2) begin
                halt_v[1] = 8'h03;
                ret_v[1]  = 8'h03;
            end
            if (i - (RST1 + 1) == 49) halt_v[1] = 8'h03;
            tick();
            if (i == 3) begin
                check("edge.hold_mask",   64'(mask_w[1]), 64'd0);
                check("edge.hold_retire", 64'(rc_w[1]),   64'd0);
            end
            if (i == RST1 + 1 + 49) begin
                check("edge.done",    64'(done_w[1]), 64'd1);
                check("edge.timeout", 64'(tout_w[1]), 64'd0);
                check("edge.cycles",  64'(cyc_w[1]),  64'd50);
            end
        end

        // Reset mid-run on u0, then restart from a clean slate.
        for (int i = 0; i < 25; i++) begin
            clear_inputs();
            if (i == 0) halt_v[0] = 8'h01;
            if (i == 1 || i == 14) start_v[0] = 1'b1;
            if (i == 11) begin
                rst_n = 1'b0;
                #1;
                check("abort.async_cycles",    64'(cyc_w[0]),       64'd0);
                check("abort.async_cpu_reset", 64'(cpu_reset_w[0]), 64'd1);
            end
            if (i == 13) rst_n = 1'b1;
            tick();
            if (i == 10) check("abort.pre_cycles", 64'(cyc_w[0]), 64'd7);
            if (i == 12) begin
                check("abort.state", 64'(st_w[0]),   64'(ST_IDLE));
                check("abort.done",  64'(done_w[0]), 64'd0);
            end
            if (i == 20) begin
                check("restart.cycles", 64'(cyc_w[0]),     64'd4);
                check("restart.run",    64'(running_w[0]), 64'd1);
            end
        end

        // Randomised traffic on all instances, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            for (int j = 0; j < NI; j++) begin
                start_v[j] = ($urandom_range(0, 29) == 0);
                halt_v[j]  = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'h00;
                ret_v[j]   = 8'($urandom);
            end
            tick();
        end

        clear_inputs();
        rst_n = 1'b1;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
